// File: rtl/up_clk_gen_pkg.sv
// ---------------------------------------------------------------------------
// up_clk_gen_pkg
// Shared types and constants for the programmable slow-clock generator.
//   state_e  : FSM state encoding (IDLE, RUN_LOW, RUN_HIGH)
//   MIN_HALF : smallest legal half-period, in enable_clk ticks
// ---------------------------------------------------------------------------
package up_clk_gen_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN_LOW  = 2'd1,
    RUN_HIGH = 2'd2
  } state_e;

  localparam int MIN_HALF = 2;

endpackage

// File: rtl/up_prog_slow_clock_gen.sv
// ---------------------------------------------------------------------------
// up_prog_slow_clock_gen
// Programmable slow-clock generator. Produces a registered, 50%-duty slow
// clock from clk, qualified by enable_clk ticks, with a runtime-loadable
// half-period, glitch-free start/stop and single-cycle edge / mid-level
// strobes. The active divisor only changes at a rising edge of new_clk
// (or directly while idle).
//
// Ports
//   clk                  in   system clock, rising edge
//   reset_n              in   asynchronous active-low reset
//   enable_clk           in   tick qualifier for the half-period counter
//   half_period[CNT_W]   in   requested half-period (ticks), captured on load
//   load                 in   pulse: capture half_period (must be >= 2)
//   start                in   pulse: begin generation (ignored if stop is high)
//   stop                 in   pulse: stop; a high phase is completed first
//   new_clk              out  generated clock
//   rising_edge          out  first cycle new_clk is 1
//   falling_edge         out  first cycle new_clk is 0 after being high
//   middle_of_high_level out  mid-point strobe of the high phase
//   middle_of_low_level  out  mid-point strobe of the low phase
//   running              out  FSM not idle
//   cfg_err              out  sticky, last load carried an illegal half_period
//
// Build option
//   SLOW_CLK_MID_STROBE_EN : when defined, the middle_of_* strobes are
//   generated; otherwise both are tied to 0 and their compare logic is absent.
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// IDLE     | not generating, new_clk = 0, load also updates active divisor
// RUN_LOW  | low half of the period, stop ends it immediately
// RUN_HIGH | high half, stop is deferred until the half completes
// ---------------------------------------------------------------------------
module up_prog_slow_clock_gen
  import up_clk_gen_pkg::*;
#(
  parameter int               CNT_W        = 16,
  parameter logic [CNT_W-1:0] DEFAULT_HALF = CNT_W'(250)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable_clk,
  input  logic [CNT_W-1:0] half_period,
  input  logic             load,
  input  logic             start,
  input  logic             stop,
  output logic             new_clk,
  output logic             rising_edge,
  output logic             falling_edge,
  output logic             middle_of_high_level,
  output logic             middle_of_low_level,
  output logic             running,
  output logic             cfg_err
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] active_q, active_d;
  logic [CNT_W-1:0] pending_q, pending_d;
  logic             stop_pend_q, stop_pend_d;
  logic             cfg_err_d;

  logic new_clk_d, running_d, rise_d, fall_d;

  logic at_end;
  logic load_ok;

  assign at_end  = (cnt_q == (active_q - CNT_W'(1)));
  assign load_ok = (half_period >= CNT_W'(MIN_HALF));

  // -------------------------------------------------------------------------
  // State and output registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      active_q     <= DEFAULT_HALF;
      pending_q    <= DEFAULT_HALF;
      stop_pend_q  <= 1'b0;
      cfg_err      <= 1'b0;
      new_clk      <= 1'b0;
      running      <= 1'b0;
      rising_edge  <= 1'b0;
      falling_edge <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      active_q     <= active_d;
      pending_q    <= pending_d;
      stop_pend_q  <= stop_pend_d;
      cfg_err      <= cfg_err_d;
      new_clk      <= new_clk_d;
      running      <= running_d;
      rising_edge  <= rise_d;
      falling_edge <= fall_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next state and divisor/counter datapath
  // -------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    active_d  = active_q;
    pending_d = pending_q;
    cfg_err_d = cfg_err;

    if (load) begin
      if (load_ok) begin
        pending_d = half_period;
        cfg_err_d = 1'b0;
      end else begin
        cfg_err_d = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (load && load_ok) active_d = half_period;
        // stop beats a coincident start
        if (start && !stop) begin
          state_d  = RUN_LOW;
          cnt_d    = '0;
          active_d = pending_d;
        end
      end

      RUN_LOW: begin
        if (stop) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (enable_clk) begin
          if (at_end) begin
            state_d  = RUN_HIGH;
            cnt_d    = '0;
            // only point where a running divisor changes
            active_d = pending_d;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      RUN_HIGH: begin
        if (enable_clk) begin
          if (at_end) begin
            state_d = (stop_pend_q || stop) ? IDLE : RUN_LOW;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // pending stop lives only while the high phase is being completed
    stop_pend_d = (state_d == RUN_HIGH) && (stop_pend_q || stop);
  end

  // -------------------------------------------------------------------------
  // Output next values; registered together with state so every output
  // changes in the same clk cycle as new_clk
  // -------------------------------------------------------------------------
  always_comb begin
    new_clk_d = (state_d == RUN_HIGH);
    running_d = (state_d != IDLE);
    rise_d    = (state_d == RUN_HIGH) && (state_q != RUN_HIGH);
    fall_d    = (state_q == RUN_HIGH) && (state_d != RUN_HIGH);
  end

`ifdef SLOW_CLK_MID_STROBE_EN
  logic mid_hi_d, mid_lo_d;

  // staying in the same phase on a tick means cnt_d is cnt_q + 1
  always_comb begin
    mid_hi_d = enable_clk && (state_q == RUN_HIGH) && (state_d == RUN_HIGH) &&
               (cnt_d == (active_q >> 1));
    mid_lo_d = enable_clk && (state_q == RUN_LOW) && (state_d == RUN_LOW) &&
               (cnt_d == (active_q >> 1));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      middle_of_high_level <= 1'b0;
      middle_of_low_level  <= 1'b0;
    end else begin
      middle_of_high_level <= mid_hi_d;
      middle_of_low_level  <= mid_lo_d;
    end
  end
`else
  assign middle_of_high_level = 1'b0;
  assign middle_of_low_level  = 1'b0;
`endif

endmodule

// File: tb/tb_up_prog_slow_clock_gen.sv
// ---------------------------------------------------------------------------
// tb_up_prog_slow_clock_gen
// Directed bench for up_prog_slow_clock_gen. Stimulus pushes hand-computed
// strobe cycles into per-strobe queues; a negedge monitor pops and compares
// whenever the DUT raises a strobe, and checks that new_clk changes only
// together with its matching edge strobe.
// ---------------------------------------------------------------------------
module tb_up_prog_slow_clock_gen;

  localparam int CNT_W = 16;

  logic             clk        = 1'b0;
  logic             reset_n    = 1'b1;
  logic             enable_clk = 1'b0;
  logic [CNT_W-1:0] half_period = '0;
  logic             load  = 1'b0;
  logic             start = 1'b0;
  logic             stop  = 1'b0;

  logic new_clk, rising_edge, falling_edge;
  logic middle_of_high_level, middle_of_low_level;
  logic running, cfg_err;

  int cyc      = 0;
  int checks   = 0;
  int failures = 0;
  int en_mode  = 0;
  logic prev_clk = 1'b0;

  int q_rise[$];
  int q_fall[$];
  int q_mhi[$];
  int q_mlo[$];

  up_prog_slow_clock_gen dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .enable_clk           (enable_clk),
    .half_period          (half_period),
    .load                 (load),
    .start                (start),
    .stop                 (stop),
    .new_clk              (new_clk),
    .rising_edge          (rising_edge),
    .falling_edge         (falling_edge),
    .middle_of_high_level (middle_of_high_level),
    .middle_of_low_level  (middle_of_low_level),
    .running              (running),
    .cfg_err              (cfg_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // en_mode 0: tick every cycle; 1: tick at edges where cyc becomes 1 mod 3
  initial begin
    forever begin
      @(posedge clk);
      #1;
      enable_clk = (en_mode == 0) ? 1'b1 : ((cyc % 3) == 0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // returns 1 ns after posedge number k
  task automatic wait_to(input int k);
    while (cyc < k) begin
      @(posedge clk);
      #1;
    end
  endtask

  // returns at the negedge following posedge number k
  task automatic wait_neg(input int k);
    while (cyc < k) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
  endtask

  task automatic chk_evt(input int kind);
    int    req;
    bit    have;
    string nm;
    have = 1'b0;
    req  = -1;
    nm   = "";
    case (kind)
      0: begin nm = "rising_edge";  if (q_rise.size() > 0) begin have = 1'b1; req = q_rise.pop_front(); end end
      1: begin nm = "falling_edge"; if (q_fall.size() > 0) begin have = 1'b1; req = q_fall.pop_front(); end end
      2: begin nm = "mid_high";     if (q_mhi.size()  > 0) begin have = 1'b1; req = q_mhi.pop_front();  end end
      default: begin nm = "mid_low"; if (q_mlo.size() > 0) begin have = 1'b1; req = q_mlo.pop_front(); end end
    endcase
    checks++;
    if (!have) begin
      failures++;
      $display("FAIL %s: strobe at cycle %0d, required none", nm, cyc);
    end else if (req != cyc) begin
      failures++;
      $display("FAIL %s: strobe at cycle %0d, required cycle %0d", nm, cyc, req);
    end
  endtask

  // monitor
  always @(negedge clk) begin
    if (reset_n !== 1'b1) begin
      prev_clk = 1'b0;
    end else begin
      if (rising_edge === 1'b1)          chk_evt(0);
      if (falling_edge === 1'b1)         chk_evt(1);
      if (middle_of_high_level === 1'b1) chk_evt(2);
      if (middle_of_low_level === 1'b1)  chk_evt(3);
      if ((new_clk !== prev_clk) || (rising_edge === 1'b1) || (falling_edge === 1'b1)) begin
        checks++;
        if ((rising_edge  !== ((new_clk === 1'b1) && (prev_clk === 1'b0))) ||
            (falling_edge !== ((new_clk === 1'b0) && (prev_clk === 1'b1)))) begin
          failures++;
          $display("FAIL edge_align: cycle %0d new_clk %b->%b rise=%b fall=%b, required strobe matching the change",
                   cyc, prev_clk, new_clk, rising_edge, falling_edge);
        end
      end
      prev_clk = new_clk;
    end
  end

  initial begin
    // ---------------- reset state
    #1 reset_n = 1'b0;
    #2;
    check("rst_new_clk", new_clk, 0);
    check("rst_running", running, 0);
    check("rst_cfg_err", cfg_err, 0);
    check("rst_rise",    rising_edge, 0);
    check("rst_fall",    falling_edge, 0);
    check("rst_mid_hi",  middle_of_high_level, 0);
    check("rst_mid_lo",  middle_of_low_level, 0);
    wait_to(3);
    reset_n = 1'b1;

    // ---------------- A: H=4, constant ticks, stop at cnt=1 of high
    wait_to(10); load = 1'b1; half_period = 16'd4;
    wait_to(11); load = 1'b0;
    wait_neg(13);
    check("A_running_pre", running, 0);
    wait_to(14); start = 1'b1;
    q_rise.push_back(19); q_rise.push_back(27);
    q_fall.push_back(23); q_fall.push_back(31);
`ifdef SLOW_CLK_MID_STROBE_EN
    q_mlo.push_back(17); q_mlo.push_back(25);
    q_mhi.push_back(21); q_mhi.push_back(29);
`endif
    wait_to(15); start = 1'b0;
    wait_neg(15);
    check("A_running_t1", running, 1);
    check("A_clk_low",    new_clk, 0);
    wait_to(28); stop = 1'b1;
    wait_to(29); stop = 1'b0;
    wait_neg(30);
    check("A_high_held",  new_clk, 1);
    check("A_run_held",   running, 1);
    wait_neg(31);
    check("A_stop_idle",  running, 0);
    check("A_stop_clk",   new_clk, 0);
    wait_neg(33);
    check("A_stays_idle", running, 0);

    // ---------------- B: H=6, tick every 3rd cycle, stop in low
    wait_to(38); en_mode = 1;
    wait_to(40); load = 1'b1; half_period = 16'd6;
    wait_to(41); load = 1'b0;
    wait_to(45); start = 1'b1;
    q_rise.push_back(64);
    q_fall.push_back(82);
`ifdef SLOW_CLK_MID_STROBE_EN
    q_mlo.push_back(55);
    q_mhi.push_back(73);
`endif
    wait_to(46); start = 1'b0;
    wait_neg(63);
    check("B_low_18", new_clk, 0);
    wait_neg(64);
    check("B_high_start", new_clk, 1);
    wait_neg(81);
    check("B_high_18", new_clk, 1);
    wait_neg(84);
    check("B_run_low", running, 1);
    wait_to(84); stop = 1'b1;
    wait_to(85); stop = 1'b0;
    wait_neg(85);
    check("B_stop_low_idle", running, 0);
    check("B_stop_low_clk",  new_clk, 0);
    wait_to(88); en_mode = 0;

    // ---------------- C: H=8, load 2 in second low phase
    wait_to(90); load = 1'b1; half_period = 16'd8;
    wait_to(91); load = 1'b0;
    wait_to(94); start = 1'b1;
    q_rise.push_back(103); q_rise.push_back(119); q_rise.push_back(123);
    q_fall.push_back(111); q_fall.push_back(121); q_fall.push_back(125);
`ifdef SLOW_CLK_MID_STROBE_EN
    q_mlo.push_back(99);  q_mlo.push_back(115); q_mlo.push_back(122); q_mlo.push_back(126);
    q_mhi.push_back(107); q_mhi.push_back(120); q_mhi.push_back(124);
`endif
    wait_to(95); start = 1'b0;
    wait_to(113); load = 1'b1; half_period = 16'd2;
    wait_to(114); load = 1'b0;
    wait_neg(118);
    check("C_low_full_8", new_clk, 0);
    wait_to(126); stop = 1'b1;
    wait_to(127); stop = 1'b0;
    wait_neg(127);
    check("C_stop_idle", running, 0);
    check("C_stop_clk",  new_clk, 0);

    // ---------------- D: illegal load, start+stop together
    wait_to(130); load = 1'b1; half_period = 16'd1;
    wait_to(131); load = 1'b0;
    wait_neg(131);
    check("D_cfg_err_set", cfg_err, 1);
    wait_to(132); start = 1'b1;
    q_rise.push_back(135);
    q_fall.push_back(137);
`ifdef SLOW_CLK_MID_STROBE_EN
    q_mlo.push_back(134);
    q_mhi.push_back(136);
`endif
    wait_to(133); start = 1'b0;
    wait_to(137); stop = 1'b1;
    wait_to(138); stop = 1'b0;
    wait_neg(138);
    check("D_stop_idle",     running, 0);
    check("D_cfg_err_stick", cfg_err, 1);
    wait_to(139); load = 1'b1; half_period = 16'd3;
    wait_to(140); load = 1'b0;
    wait_neg(140);
    check("D_cfg_err_clr", cfg_err, 0);
    wait_to(141); start = 1'b1; stop = 1'b1;
    wait_to(142); start = 1'b0; stop = 1'b0;
    wait_neg(142);
    check("D_startstop_idle", running, 0);
    wait_neg(143);
    check("D_startstop_idle2", running, 0);
    check("D_startstop_clk",   new_clk, 0);

    // ---------------- E: async reset mid-high, then default divisor
    wait_to(144); load = 1'b1; half_period = 16'd5;
    wait_to(145); load = 1'b0;
    wait_to(146); start = 1'b1;
    q_rise.push_back(152);
`ifdef SLOW_CLK_MID_STROBE_EN
    q_mlo.push_back(149);
`endif
    wait_to(147); start = 1'b0;
    wait_neg(152);
    check("E_high_before_rst", new_clk, 1);
    #2 reset_n = 1'b0;
    #1;
    check("E_rst_clk",  new_clk, 0);
    check("E_rst_run",  running, 0);
    check("E_rst_rise", rising_edge, 0);
    wait_to(155); reset_n = 1'b1;
    wait_neg(156);
    check("E_post_rst_run", running, 0);
    check("E_post_rst_clk", new_clk, 0);
    wait_to(159); start = 1'b1;
    q_rise.push_back(410);
    q_fall.push_back(660);
`ifdef SLOW_CLK_MID_STROBE_EN
    q_mlo.push_back(285);
    q_mhi.push_back(535);
`endif
    wait_to(160); start = 1'b0;
    wait_neg(409);
    check("E_default_low", new_clk, 0);
    wait_neg(410);
    check("E_default_high", new_clk, 1);
    wait_to(499); stop = 1'b1;
    wait_to(500); stop = 1'b0;
    wait_neg(659);
    check("E_pend_high", new_clk, 1);
    check("E_pend_run",  running, 1);
    wait_neg(660);
    check("E_end_idle", running, 0);
    check("E_end_clk",  new_clk, 0);

    wait_neg(670);
    check("left_rise", q_rise.size(), 0);
    check("left_fall", q_fall.size(), 0);
`ifdef SLOW_CLK_MID_STROBE_EN
    check("left_mid_hi", q_mhi.size(), 0);
    check("left_mid_lo", q_mlo.size(), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
